// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encoding,
// parity-type constants and the majority vote used by the bit sampler.
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling tick counter plus 3-sample majority bit sampler; produces the
// voted bit value together with the vote-tick and end-of-bit strobes.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic rx_in,
    output logic vote,
    output logic vote_tick,
    output logic bit_end
);

    localparam int TW = $clog2(OVS);

    logic [TW-1:0] tick;
    logic          samp_a;
    logic          samp_b;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick <= '0;
        end else if (tick == TW'(OVS - 1)) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (tick == TW'(OVS / 2 - 1)) samp_a <= rx_in;
            if (tick == TW'(OVS / 2))     samp_b <= rx_in;
        end
    end

    // The third sample is the line value at the vote tick itself, so the
    // voted bit is usable on the same edge that takes that sample.
    assign vote      = maj3(samp_a, samp_b, rx_in);
    assign vote_tick = (tick == TW'(OVS / 2 + 1));
    assign bit_end   = (tick == TW'(OVS - 1));

endmodule

// File: rtl/uart_rx_fsm_param.sv
// Parametrised UART receive engine: frame FSM, deserialiser, parity check and
// registered end-of-frame pulses, fed by the oversampling bit sampler.
module uart_rx_fsm_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              stop_2,
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stop_err,
    output logic              busy
);

    localparam int BC_W = $clog2(DATA_W + 1);

    state_t            state;
    state_t            state_nx;
    logic              vote;
    logic              vote_tick;
    logic              bit_end;
    logic              cfg_par;
    logic              cfg_typ;
    logic              cfg_stop2;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_acc;
    logic              par_bad;
    logic              stop_bad;
    logic              brk_hold;
    logic              start_det;
    logic              last_data;
    logic              last_stop;
    logic              frame_end;
    logic              stop_bad_fin;

    uart_rx_sampler #(.OVS(OVS)) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == ST_IDLE),
        .rx_in     (rx_in),
        .vote      (vote),
        .vote_tick (vote_tick),
        .bit_end   (bit_end)
    );

    assign start_det    = (state == ST_IDLE) && !rx_in && !brk_hold;
    assign last_data    = (bit_cnt == BC_W'(DATA_W - 1));
    assign last_stop    = !cfg_stop2 || (bit_cnt == BC_W'(1));
    // Frame closes at the vote of the last stop bit to tolerate baud drift.
    assign frame_end    = (state == ST_STOP) && vote_tick && last_stop;
    assign stop_bad_fin = stop_bad | ~vote;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start_det) state_nx = ST_START;
            end
            ST_START: begin
                if (vote_tick && vote) state_nx = ST_IDLE;
                else if (bit_end)      state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_data) state_nx = cfg_par ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (frame_end) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cfg_par    <= 1'b0;
            cfg_typ    <= PAR_EVEN;
            cfg_stop2  <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            brk_hold   <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_in) brk_hold <= 1'b0;
                    if (start_det) begin
                        cfg_par   <= par_en;
                        cfg_typ   <= par_typ;
                        cfg_stop2 <= stop_2;
                        bit_cnt   <= '0;
                        par_acc   <= 1'b0;
                        par_bad   <= 1'b0;
                        stop_bad  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (vote_tick) begin
                        shreg   <= {vote, shreg[DATA_W-1:1]};
                        par_acc <= par_acc ^ vote;
                    end
                    if (bit_end) bit_cnt <= last_data ? '0 : bit_cnt + BC_W'(1);
                end
                ST_PARITY: begin
                    if (vote_tick) par_bad <= ((par_acc ^ vote) != (cfg_typ == PAR_ODD));
                end
                ST_STOP: begin
                    if (vote_tick) stop_bad <= stop_bad_fin;
                    if (bit_end)   bit_cnt  <= bit_cnt + BC_W'(1);
                    if (frame_end) begin
                        par_err  <= par_bad;
                        stop_err <= stop_bad_fin;
                        brk_hold <= stop_bad_fin;
                        if (!par_bad && !stop_bad_fin) begin
                            data_valid <= 1'b1;
                            p_data     <= shreg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm_param.sv
// Self-checking bench for uart_rx_fsm_param: frames are built from the line
// protocol rules and every end-of-frame pulse is matched against a queue.
module tb_uart_rx_fsm_param;

  localparam int DATA_W = 8;
  localparam int OVS    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_in = 1'b1;
  logic              par_en = 1'b0;
  logic              par_typ = 1'b0;
  logic              stop_2 = 1'b0;
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              par_err;
  logic              stop_err;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // {cycle[31:0], valid, par_err, stop_err, 4'b0, p_data[8:0]}
  logic [47:0]       exp_q[$];
  logic [47:0]       mon_e;
  logic [DATA_W-1:0] model_pdata = '0;

  uart_rx_fsm_param #(.DATA_W(DATA_W), .OVS(OVS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop_2     (stop_2),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .busy       (busy)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every output pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && (data_valid || par_err || stop_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'b0, data_valid, par_err, stop_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), mon_e[47:16]);
        check("data_valid", 32'(data_valid), 32'(mon_e[15]));
        check("par_err", 32'(par_err), 32'(mon_e[14]));
        check("stop_err", 32'(stop_err), 32'(mon_e[13]));
        check("p_data", 32'(p_data), 32'(mon_e[8:0]));
        check("busy_at_end", 32'(busy), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_in = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic b, input logic glitch, output int first);
    for (int i = 0; i < OVS; i++) begin
      @(posedge clk); #1;
      if (i == 0) first = cyc;
      rx_in = (glitch && i == OVS / 2 + 1) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                            input logic s2, input logic bad_par, input logic [1:0] stops,
                            input int gbit);
    int   c;
    int   tmp;
    int   n;
    logic pbit;
    logic perr;
    logic serr;
    logic ok;
    par_en  = pe;
    par_typ = pt;
    stop_2  = s2;
    pbit = (^d) ^ pt ^ bad_par;
    perr = pe && bad_par;
    serr = !stops[0] || (s2 && !stops[1]);
    ok   = !perr && !serr;
    n    = 1 + DATA_W + int'(pe) + 1 + int'(s2);
    drive_bit(1'b0, gbit == 0, c);
    if (ok) model_pdata = d;
    exp_q.push_back({32'(c + 1 + (n - 1) * OVS + OVS / 2 + 2), ok, perr, serr, 4'b0,
                     9'(model_pdata)});
    // configuration must be ignored once the frame is under way
    par_en  = 1'($urandom_range(0, 1));
    par_typ = 1'($urandom_range(0, 1));
    stop_2  = 1'($urandom_range(0, 1));
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i], gbit == i + 1, tmp);
    if (pe) drive_bit(pbit, gbit == DATA_W + 1, tmp);
    drive_bit(stops[0], 1'b0, tmp);
    if (s2) drive_bit(stops[1], 1'b0, tmp);
  endtask

  initial begin
    int c;
    int tmp;
    logic [DATA_W-1:0] d;
    logic pe;
    logic s2;
    logic bp;
    logic [1:0] st;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_stop_err", 32'(stop_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(4);

    // basic frame, no parity, one stop
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1);
    idle(3);

    // even parity good, then bad parity bit
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, -1);
    idle(2);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, -1);
    idle(2);

    // false start: line low for two cycles only
    @(posedge clk); #1;
    c = cyc;
    rx_in = 1'b0;
    @(posedge clk); #1;
    rx_in = 1'b0;
    @(posedge clk); #1;
    rx_in = 1'b1;
    repeat (c + 6 - cyc) @(posedge clk);
    #1;
    check("false_start_busy_rel5", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("false_start_busy_rel6", 32'(busy), 32'd0);
    idle(3);

    // one flipped sample inside a data bit is outvoted
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3);
    idle(1);

    // bad stop bit followed by a held-low line
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      rx_in = 1'b0;
    end
    check("break_hold_busy", 32'(busy), 32'd0);
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1);
    idle(2);

    // two stop bits: second bad, then both good
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, -1);
    idle(2);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, -1);
    idle(2);

    // reset during data bit 4 aborts the frame
    d = 8'h99;
    drive_bit(1'b0, 1'b0, c);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0, tmp);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rx_in = d[4];
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_pdata = '0;
    check("abort_p_data", 32'(p_data), 32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_par_err", 32'(par_err), 32'd0);
    check("abort_stop_err", 32'(stop_err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    idle(2 * OVS);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1);
    idle(2);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      d  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      pe = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(d, pe, 1'($urandom_range(0, 1)), s2, bp, st,
                 int'($urandom_range(0, DATA_W + 2)) - 1);
      idle(((!st[0]) || (s2 && !st[1])) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
    end

    idle(3 * OVS);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
